// File: rtl/pdm_modulator.sv
// Second-order sigma-delta modulator: signed PCM samples in through a 2-entry
// ready/valid FIFO, one PDM bit out per tick, each sample held for OSR bits.
module pdm_modulator #(
  parameter int DW  = 16,
  parameter int OSR = 64,
  parameter int DIV = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] pcm_in,
  input  logic          pcm_valid,
  output logic          pcm_ready,
  output logic          pdm_out,
  output logic          pdm_strobe,
  output logic          underrun,
  input  logic          clr_underrun
);

  localparam int AW  = DW + 4;
  localparam int XW  = AW + 2;
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(OSR);

  // Arithmetic runs two bits wider than the accumulators so sat() sees the true sum.
  localparam logic signed [XW-1:0] FS      = {{(XW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
  localparam logic signed [XW-1:0] SAT_MAX = {3'b000, {(AW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {3'b111, {(AW-1){1'b0}}};

  logic [DW-1:0]        fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           fifo_cnt;
  logic                 push;
  logic                 pop;

  logic [DCW-1:0]       div_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic                 tick;
  logic                 boundary;

  logic [DW-1:0]        cur_sample;
  logic signed [AW-1:0] i1;
  logic signed [AW-1:0] i2;
  logic signed [AW-1:0] i1_nxt;
  logic signed [AW-1:0] i2_nxt;
  logic signed [XW-1:0] x_ext;
  logic signed [XW-1:0] fb;
  logic signed [XW-1:0] sum1;
  logic signed [XW-1:0] sum2;

  function automatic logic signed [AW-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[AW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[AW-1:0];
    else                  return v[AW-1:0];
  endfunction

  assign pcm_ready = (fifo_cnt != 2'd2);
  assign tick      = en && (div_cnt == DCW'(DIV - 1));
  assign boundary  = tick && (bit_cnt == BCW'(OSR - 1));
  assign push      = pcm_valid && pcm_ready;
  // No bypass: a sample pushed this cycle cannot satisfy this cycle's boundary.
  assign pop       = boundary && (fifo_cnt != 2'd0);

  always_comb begin
    x_ext  = {{(XW-DW){cur_sample[DW-1]}}, cur_sample};
    fb     = pdm_out ? FS : -FS;
    sum1   = {{2{i1[AW-1]}}, i1} + x_ext - fb;
    i1_nxt = sat(sum1);
    sum2   = {{2{i2[AW-1]}}, i2} + {{2{i1_nxt[AW-1]}}, i1_nxt} - fb;
    i2_nxt = sat(sum2);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pcm_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // A boundary tick still modulates with the old cur_sample; the popped one applies next tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      i1         <= '0;
      i2         <= '0;
      pdm_out    <= 1'b0;
      pdm_strobe <= 1'b0;
      underrun   <= 1'b0;
      cur_sample <= '0;
    end else begin
      pdm_strobe <= tick;
      if (en) div_cnt <= tick ? '0 : div_cnt + DCW'(1);
      if (tick) begin
        bit_cnt <= boundary ? '0 : bit_cnt + BCW'(1);
        i1      <= i1_nxt;
        i2      <= i2_nxt;
        pdm_out <= ~i2_nxt[AW-1];
      end
      if (pop) cur_sample <= fifo_mem[rd_ptr];
      if (boundary && (fifo_cnt == 2'd0)) underrun <= 1'b1;
      else if (clr_underrun)              underrun <= 1'b0;
    end
  end

endmodule
